// File: rtl/door_lock_pkg.sv
// Shared types for the door lock controller: FSM state encoding and default code width.
// Ports: none (package only).
// Imported by door_lock_ctrl and available to door_lock_timer users.
package door_lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
  } state_e;

  localparam int DEFAULT_CODE_LEN = 4;

endpackage

// File: rtl/door_lock_timer.sv
// Loadable down-counter with a done flag, used for the door-open / lockout windows
// and the optional inter-bit timeout.
// Ports: clk, reset (sync, active-low), load_i/load_val_i (load count), en_i (decrement),
//        done_o (high while the count is on its last cycle).
module door_lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // A window loaded with N is held for N enabled cycles; the Nth one sees count==1.
  assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/door_lock_ctrl.sv
// Serial keypad lock: shifts in a CODE_LEN-bit code, compares with the stored code,
// opens for OPEN_CYCLES on match, counts failures and locks out after MAX_FAILS.
// Ports: clk, reset (sync, active-low), bit_valid/bit_in/clear (entry), prog_en/prog_code
//        (reprogram while open); outputs door_open, busy, locked_out, alarm, fail_cnt, entry_cnt.
// Optional: define DOOR_LOCK_TIMEOUT_EN to abort stalled entries after TIMEOUT_CYCLES idle cycles.
module door_lock_ctrl
  import door_lock_pkg::*;
#(
  parameter int                  CODE_LEN       = DEFAULT_CODE_LEN,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 4'b1011,
  parameter int                  OPEN_CYCLES    = 8,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  LOCKOUT_CYCLES = 16,
  parameter int                  TIMEOUT_CYCLES = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             bit_valid,
  input  logic                             bit_in,
  input  logic                             clear,
  input  logic                             prog_en,
  input  logic [CODE_LEN-1:0]              prog_code,
  output logic                             door_open,
  output logic                             busy,
  output logic                             locked_out,
  output logic                             alarm,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt,
  output logic [$clog2(CODE_LEN+1)-1:0]    entry_cnt
);

  localparam int FW    = $clog2(MAX_FAILS + 1);
  localparam int EW    = $clog2(CODE_LEN + 1);
  localparam int MAXW1 = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int MAXW  = (MAXW1 > TIMEOUT_CYCLES) ? MAXW1 : TIMEOUT_CYCLES;
  localparam int TW    = $clog2(MAXW + 1);

  state_e               state_q, state_d;
  logic [CODE_LEN-1:0]  code_q, code_d;
  logic [CODE_LEN-1:0]  shift_q, shift_d;
  logic [EW-1:0]        entry_cnt_q, entry_cnt_d;
  logic [FW-1:0]        fail_cnt_q, fail_cnt_d;
  logic                 door_open_q, door_open_d;
  logic                 busy_q, busy_d;
  logic                 locked_out_q, locked_out_d;
  logic                 alarm_q, alarm_d;

  logic                 win_load, win_done, fail_evt;
  logic [TW-1:0]        win_val;

  // OPEN and LOCKOUT are mutually exclusive, so they share one window timer.
  door_lock_timer #(.W(TW)) u_win_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (win_load),
    .load_val_i (win_val),
    .en_i       ((state_q == OPEN) || (state_q == LOCKOUT)),
    .done_o     (win_done)
  );

`ifdef DOOR_LOCK_TIMEOUT_EN
  logic to_done;
  // Reloaded on every accepted bit; counts down only while waiting in ENTRY.
  door_lock_timer #(.W(TW)) u_to_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (bit_valid && ((state_q == IDLE) || ((state_q == ENTRY) && !clear))),
    .load_val_i (TW'(TIMEOUT_CYCLES)),
    .en_i       (state_q == ENTRY),
    .done_o     (to_done)
  );
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      code_q       <= DEFAULT_CODE;
      shift_q      <= '0;
      entry_cnt_q  <= '0;
      fail_cnt_q   <= '0;
      door_open_q  <= 1'b0;
      busy_q       <= 1'b0;
      locked_out_q <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      shift_q      <= shift_d;
      entry_cnt_q  <= entry_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      door_open_q  <= door_open_d;
      busy_q       <= busy_d;
      locked_out_q <= locked_out_d;
      alarm_q      <= alarm_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    shift_d     = shift_q;
    entry_cnt_d = entry_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    win_load    = 1'b0;
    win_val     = '0;
    fail_evt    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bit_valid) begin
          shift_d     = {shift_q[CODE_LEN-2:0], bit_in};
          entry_cnt_d = EW'(1);
          state_d     = (CODE_LEN == 1) ? CHECK : ENTRY;
        end
      end
      ENTRY: begin
        if (clear) begin
          shift_d     = '0;
          entry_cnt_d = '0;
          state_d     = IDLE;
        end else if (bit_valid) begin
          shift_d     = {shift_q[CODE_LEN-2:0], bit_in};
          entry_cnt_d = entry_cnt_q + EW'(1);
          if (entry_cnt_q == EW'(CODE_LEN - 1)) state_d = CHECK;
        end
`ifdef DOOR_LOCK_TIMEOUT_EN
        else if (to_done) begin
          fail_evt = 1'b1;
        end
`endif
      end
      CHECK: begin
        if (shift_q == code_q) begin
          fail_cnt_d  = '0;
          entry_cnt_d = '0;
          shift_d     = '0;
          state_d     = OPEN;
          win_load    = 1'b1;
          win_val     = TW'(OPEN_CYCLES);
        end else begin
          fail_evt = 1'b1;
        end
      end
      OPEN: begin
        if (prog_en) begin
          code_d  = prog_code;
          state_d = IDLE;
        end else if (win_done) begin
          state_d = IDLE;
        end
      end
      LOCKOUT: begin
        if (win_done) begin
          fail_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Failed entry (mismatch in CHECK or timeout abort in ENTRY).
    if (fail_evt) begin
      shift_d     = '0;
      entry_cnt_d = '0;
      if ((int'(fail_cnt_q) + 1) < MAX_FAILS) begin
        fail_cnt_d = fail_cnt_q + FW'(1);
        state_d    = IDLE;
      end else begin
        fail_cnt_d = FW'(MAX_FAILS);
        state_d    = LOCKOUT;
        win_load   = 1'b1;
        win_val    = TW'(LOCKOUT_CYCLES);
      end
    end
  end

  // Output decode from the next state so the registered outputs line up with state_q.
  always_comb begin
    door_open_d  = (state_d == OPEN);
    busy_d       = (state_d == ENTRY) || (state_d == CHECK);
    locked_out_d = (state_d == LOCKOUT);
    alarm_d      = (state_d == LOCKOUT) && (state_q != LOCKOUT);
  end

  assign door_open  = door_open_q;
  assign busy       = busy_q;
  assign locked_out = locked_out_q;
  assign alarm      = alarm_q;
  assign fail_cnt   = fail_cnt_q;
  assign entry_cnt  = entry_cnt_q;

endmodule

// File: tb/tb_door_lock_ctrl.sv
module tb_door_lock_ctrl;

  logic       clk = 1'b0;
  logic       reset, bit_valid, bit_in, clear, prog_en;
  logic [3:0] prog_code;
  logic       door_open, busy, locked_out, alarm;
  logic [1:0] fail_cnt;
  logic [2:0] entry_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  door_lock_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .clear      (clear),
    .prog_en    (prog_en),
    .prog_code  (prog_code),
    .door_open  (door_open),
    .busy       (busy),
    .locked_out (locked_out),
    .alarm      (alarm),
    .fail_cnt   (fail_cnt),
    .entry_cnt  (entry_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    step();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_code(input logic [3:0] c);
    for (int i = 3; i >= 0; i--) send_bit(c[i]);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!door_open && !locked_out) break;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0; prog_en = 1'b0; prog_code = 4'h0;
    step(); step();
    tests_run++;
    if ({door_open, busy, locked_out, alarm, fail_cnt, entry_cnt} !== 9'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 000000000", {door_open, busy, locked_out, alarm, fail_cnt, entry_cnt});
    end
    reset = 1'b1;
  endtask

  task automatic test_open();
    int n;
    send_code(4'b1011);
    tests_run++;
    if ({busy, door_open, entry_cnt} !== {1'b1, 1'b0, 3'd4}) begin
      tests_failed++;
      $display("FAIL open_check_cycle: busy/door/entry got %b %b %0d expected 1 0 4", busy, door_open, entry_cnt);
    end
    step();
    tests_run++;
    if ({door_open, busy, fail_cnt, entry_cnt} !== {1'b1, 1'b0, 2'd0, 3'd0}) begin
      tests_failed++;
      $display("FAIL open_rise: door/busy/fail/entry got %b %b %0d %0d expected 1 0 0 0", door_open, busy, fail_cnt, entry_cnt);
    end
    n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (door_open) n++;
      else break;
    end
    tests_run++;
    if (n != 8) begin
      tests_failed++;
      $display("FAIL open_width: got %0d cycles expected 8", n);
    end
  endtask

  task automatic test_lockout();
    int n, alarms, entry_seen;
    send_code(4'b1111); step();
    tests_run++;
    if (fail_cnt !== 2'd1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL fail_1: fail/busy got %0d %b expected 1 0", fail_cnt, busy);
    end
    send_code(4'b1111); step();
    tests_run++;
    if (fail_cnt !== 2'd2 || locked_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL fail_2: fail/locked got %0d %b expected 2 0", fail_cnt, locked_out);
    end
    send_code(4'b1111); step();
    tests_run++;
    if ({locked_out, alarm, fail_cnt} !== {1'b1, 1'b1, 2'd3}) begin
      tests_failed++;
      $display("FAIL lockout_entry: locked/alarm/fail got %b %b %0d expected 1 1 3", locked_out, alarm, fail_cnt);
    end
    n = 1; alarms = 1; entry_seen = 0;
    bit_valid = 1'b1; bit_in = 1'b1; clear = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (alarm) alarms++;
      if (entry_cnt != 3'd0 || busy) entry_seen++;
      if (locked_out) n++;
      else break;
    end
    bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0;
    tests_run++;
    if (n != 16 || alarms != 1) begin
      tests_failed++;
      $display("FAIL lockout_width: cycles/alarms got %0d %0d expected 16 1", n, alarms);
    end
    tests_run++;
    if (entry_seen != 0 || fail_cnt !== 2'd0 || entry_cnt !== 3'd0) begin
      tests_failed++;
      $display("FAIL lockout_exit: ignored-viol/fail/entry got %0d %0d %0d expected 0 0 0", entry_seen, fail_cnt, entry_cnt);
    end
  endtask

  task automatic test_clear();
    send_code(4'b1111); step();
    clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    step();
    clear = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    tests_run++;
    if ({busy, entry_cnt, fail_cnt} !== {1'b1, 3'd1, 2'd1}) begin
      tests_failed++;
      $display("FAIL clear_in_idle: busy/entry/fail got %b %0d %0d expected 1 1 1", busy, entry_cnt, fail_cnt);
    end
    clear = 1'b1; step(); clear = 1'b0;
    send_bit(1'b1); send_bit(1'b0);
    tests_run++;
    if (entry_cnt !== 3'd2 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_pre: entry/busy got %0d %b expected 2 1", entry_cnt, busy);
    end
    clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    step();
    clear = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    tests_run++;
    if ({busy, entry_cnt, fail_cnt} !== {1'b0, 3'd0, 2'd1}) begin
      tests_failed++;
      $display("FAIL clear_priority: busy/entry/fail got %b %0d %0d expected 0 0 1", busy, entry_cnt, fail_cnt);
    end
    send_code(4'b1011); step();
    tests_run++;
    if (door_open !== 1'b1 || fail_cnt !== 2'd0) begin
      tests_failed++;
      $display("FAIL clear_then_open: door/fail got %b %0d expected 1 0", door_open, fail_cnt);
    end
    wait_idle();
  endtask

  task automatic test_prog();
    send_code(4'b1011); step();
    prog_code = 4'b0110; prog_en = 1'b1;
    step();
    prog_en = 1'b0;
    tests_run++;
    if (door_open !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL prog_early_exit: door/busy got %b %b expected 0 0", door_open, busy);
    end
    send_code(4'b1011); step();
    tests_run++;
    if (door_open !== 1'b0 || fail_cnt !== 2'd1) begin
      tests_failed++;
      $display("FAIL prog_old_code: door/fail got %b %0d expected 0 1", door_open, fail_cnt);
    end
    send_code(4'b0110); step();
    tests_run++;
    if (door_open !== 1'b1 || fail_cnt !== 2'd0) begin
      tests_failed++;
      $display("FAIL prog_new_code: door/fail got %b %0d expected 1 0", door_open, fail_cnt);
    end
    wait_idle();
    prog_code = 4'b1111; prog_en = 1'b1;
    step();
    prog_en = 1'b0;
    send_code(4'b0110); step();
    tests_run++;
    if (door_open !== 1'b1) begin
      tests_failed++;
      $display("FAIL prog_ignored_idle: door got %b expected 1", door_open);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    send_code(4'b1111); step();
    send_bit(1'b0); send_bit(1'b1);
    reset = 1'b0; step(); reset = 1'b1;
    tests_run++;
    if ({door_open, busy, locked_out, alarm, fail_cnt, entry_cnt} !== 9'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_entry: got %b expected 000000000", {door_open, busy, locked_out, alarm, fail_cnt, entry_cnt});
    end
    send_code(4'b1011); step();
    tests_run++;
    if (door_open !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_code_restored: door got %b expected 1", door_open);
    end
    step();
    reset = 1'b0; step(); reset = 1'b1;
    tests_run++;
    if (door_open !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_open: door/busy got %b %b expected 0 0", door_open, busy);
    end
    send_bit(1'b1);
    tests_run++;
    if (entry_cnt !== 3'd1) begin
      tests_failed++;
      $display("FAIL reset_to_idle: entry got %0d expected 1", entry_cnt);
    end
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic test_timeout();
    send_bit(1'b1); send_bit(1'b0);
`ifdef DOOR_LOCK_TIMEOUT_EN
    for (int i = 0; i < 31; i++) step();
    tests_run++;
    if (busy !== 1'b1 || entry_cnt !== 3'd2) begin
      tests_failed++;
      $display("FAIL timeout_early: busy/entry got %b %0d expected 1 2", busy, entry_cnt);
    end
    step();
    tests_run++;
    if ({busy, entry_cnt, fail_cnt} !== {1'b0, 3'd0, 2'd1}) begin
      tests_failed++;
      $display("FAIL timeout_abort: busy/entry/fail got %b %0d %0d expected 0 0 1", busy, entry_cnt, fail_cnt);
    end
`else
    for (int i = 0; i < 100; i++) step();
    tests_run++;
    if (busy !== 1'b1 || entry_cnt !== 3'd2 || fail_cnt !== 2'd0) begin
      tests_failed++;
      $display("FAIL no_timeout: busy/entry/fail got %b %0d %0d expected 1 2 0", busy, entry_cnt, fail_cnt);
    end
    clear = 1'b1; step(); clear = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || entry_cnt !== 3'd0) begin
      tests_failed++;
      $display("FAIL no_timeout_clear: busy/entry got %b %0d expected 0 0", busy, entry_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_open();
    test_lockout();
    test_clear();
    test_prog();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
